// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: sequences sampling, deserialising and the
// start/parity/stop checks for one 8N1 or 8-bit-plus-parity frame at 8x oversampling.
module uart_rx_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PAR_EN,
  input  logic       RX_IN,
  input  logic [3:0] bit_cnt,
  input  logic [2:0] edge_cnt,
  input  logic       par_err,
  input  logic       strt_glitch,
  input  logic       stp_err,
  output logic       dat_samp_en,
  output logic       enable,
  output logic       deser_en,
  output logic       data_valid,
  output logic       stp_chk_en,
  output logic       strt_chk_en,
  output logic       par_chk_en
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StValid  = 3'd5;

  localparam logic [2:0] LastEdge    = 3'd7;
  localparam logic [3:0] LastDataBit = 4'd8;

  logic [2:0] state_q, state_d;
  logic       bit_end;
  logic       last_data_bit;

  assign bit_end       = (edge_cnt == LastEdge);
  assign last_data_bit = (bit_cnt == LastDataBit);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Each checker result is only trusted at the bit end of the state that owns it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!RX_IN) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = strt_glitch ? StIdle : StData;
      end
      StData: begin
        if (bit_end && last_data_bit) state_d = PAR_EN ? StParity : StStop;
      end
      StParity: begin
        if (bit_end) state_d = par_err ? StIdle : StStop;
      end
      StStop: begin
        if (bit_end) state_d = stp_err ? StIdle : StValid;
      end
      StValid: begin
        // A low line here is the next frame's start bit; skip IDLE.
        state_d = RX_IN ? StIdle : StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enable      = 1'b0;
    dat_samp_en = 1'b0;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      StStart: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
      end
      StData: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = 1'b1;
      end
      StParity: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
      end
      StStop: begin
        enable      = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
      end
      StValid: begin
        data_valid  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: each driven cycle queues the output pattern of the
// state the frame should be in after that edge, popped and compared one step later.
module tb_uart_rx_fsm;

  // {enable, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}
  localparam logic [6:0] OIdle   = 7'b000_0000;
  localparam logic [6:0] OStart  = 7'b111_0000;
  localparam logic [6:0] OData   = 7'b110_1000;
  localparam logic [6:0] OParity = 7'b110_0100;
  localparam logic [6:0] OStop   = 7'b110_0010;
  localparam logic [6:0] OValid  = 7'b000_0001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       RX_IN = 1'b1;
  logic [3:0] bit_cnt = '0;
  logic [2:0] edge_cnt = '0;
  logic       par_err = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en, enable, deser_en, data_valid, stp_chk_en, strt_chk_en, par_chk_en;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  uart_rx_fsm dut (
    .CLK        (CLK),
    .RST        (RST),
    .PAR_EN     (PAR_EN),
    .RX_IN      (RX_IN),
    .bit_cnt    (bit_cnt),
    .edge_cnt   (edge_cnt),
    .par_err    (par_err),
    .strt_glitch(strt_glitch),
    .stp_err    (stp_err),
    .dat_samp_en(dat_samp_en),
    .enable     (enable),
    .deser_en   (deser_en),
    .data_valid (data_valid),
    .stp_chk_en (stp_chk_en),
    .strt_chk_en(strt_chk_en),
    .par_chk_en (par_chk_en)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] outs();
    return {enable, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid};
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: outputs got %b want %b", tag, got, exp);
  endtask

  // Drive one cycle of stimulus; errs = {strt_glitch, par_err, stp_err}.
  task automatic cyc(input string tag, input logic rx, input logic [2:0] e,
                     input logic [3:0] b, input logic [2:0] errs, input logic [6:0] exp);
    RX_IN = rx;
    edge_cnt = e;
    bit_cnt = b;
    {strt_glitch, par_err, stp_err} = errs;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: queue got empty want entry");
    end else begin
      check(tag_q.pop_front(), outs(), exp_q.pop_front());
    end
  endtask

  initial begin
    #2;
    check("reset_held", outs(), OIdle);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Idle line stays idle
    cyc("idle_hold", 1'b1, 3'd7, 4'd0, 3'b111, OIdle);

    // No-parity frame, with off-bit-end and foreign error inputs that must be ignored
    PAR_EN = 1'b0;
    cyc("np_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("np_start_glitch_mid", 1'b1, 3'd3, 4'd0, 3'b100, OStart);
    cyc("np_to_data", 1'b1, 3'd7, 4'd0, 3'b011, OData);
    cyc("np_data_bit3_end", 1'b1, 3'd7, 4'd3, 3'b000, OData);
    cyc("np_data_bit8_mid", 1'b1, 3'd5, 4'd8, 3'b000, OData);
    cyc("np_to_stop", 1'b1, 3'd7, 4'd8, 3'b000, OStop);
    cyc("np_stop_err_mid", 1'b1, 3'd2, 4'd9, 3'b001, OStop);
    cyc("np_to_valid", 1'b1, 3'd7, 4'd9, 3'b110, OValid);
    cyc("np_valid_to_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);
    cyc("np_idle_after", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Parity frame; PAR_EN only matters at the DATA decision
    PAR_EN = 1'b0;
    cyc("p_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("p_to_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    PAR_EN = 1'b1;
    cyc("p_to_parity", 1'b1, 3'd7, 4'd8, 3'b000, OParity);
    PAR_EN = 1'b0;
    cyc("p_parity_err_mid", 1'b1, 3'd4, 4'd9, 3'b010, OParity);
    cyc("p_to_stop", 1'b1, 3'd7, 4'd9, 3'b101, OStop);
    cyc("p_to_valid", 1'b1, 3'd7, 4'd10, 3'b000, OValid);
    cyc("p_to_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Start glitch
    cyc("g_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("g_abort", 1'b0, 3'd7, 4'd0, 3'b100, OIdle);
    cyc("g_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Parity error
    PAR_EN = 1'b1;
    cyc("pe_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("pe_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    cyc("pe_parity", 1'b1, 3'd7, 4'd8, 3'b000, OParity);
    cyc("pe_abort", 1'b1, 3'd7, 4'd9, 3'b010, OIdle);
    cyc("pe_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Stop error
    PAR_EN = 1'b0;
    cyc("se_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("se_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    cyc("se_stop", 1'b1, 3'd7, 4'd8, 3'b000, OStop);
    cyc("se_abort", 1'b1, 3'd7, 4'd9, 3'b001, OIdle);
    cyc("se_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Back-to-back frames
    cyc("bb1_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("bb1_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    cyc("bb1_stop", 1'b1, 3'd7, 4'd8, 3'b000, OStop);
    cyc("bb1_valid", 1'b1, 3'd7, 4'd9, 3'b000, OValid);
    cyc("bb2_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("bb2_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    cyc("bb2_stop", 1'b1, 3'd7, 4'd8, 3'b000, OStop);
    cyc("bb2_valid", 1'b1, 3'd7, 4'd9, 3'b000, OValid);
    cyc("bb2_idle", 1'b1, 3'd0, 4'd0, 3'b000, OIdle);

    // Asynchronous reset in the middle of a frame
    cyc("rst_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);
    cyc("rst_data", 1'b1, 3'd7, 4'd0, 3'b000, OData);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_clear", outs(), OIdle);
    @(posedge CLK);
    #1;
    check("rst_held_edge", outs(), OIdle);
    @(negedge CLK);
    RST = 1'b0;
    cyc("rst_after_idle", 1'b1, 3'd7, 4'd9, 3'b000, OIdle);
    cyc("rst_new_start", 1'b0, 3'd0, 4'd0, 3'b000, OStart);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time got %0t want finish before 100000", $time);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Control state machine of the UART receiver. Watches the serial line and the receiver's oversampling counters (8 samples per bit, `edge_cnt` 0..7, `bit_cnt` = bit index in frame) and sequences the sampler, deserializer, and start/parity/stop checkers. It also raises `data_valid` for one cycle after each error-free frame. Frame: 1 start bit (0), 8 data bits, optional parity bit, 1 stop bit (1).

## Interface
Parameters: none (8 data bits, oversampling ratio 8 fixed).
- CLK  in  1  receiver oversampling clock (8× baud); state updates on rising edge
- RST  in  1  asynchronous reset, active-high
- PAR_EN  in  1  1 = frame carries a parity bit
- RX_IN  in  1  serial line, idle high
- bit_cnt  in  4  current bit index from edge/bit counter (0 = start, 1..8 = data, 9 = parity or stop, 10 = stop with parity)
- edge_cnt  in  3  sample index within current bit, 0..7
- par_err  in  1  parity checker result, valid while `par_chk_en`
- strt_glitch  in  1  start checker result, valid while `strt_chk_en`
- stp_err  in  1  stop checker result, valid while `stp_chk_en`
- dat_samp_en  out  1  enable data sampler
- enable  out  1  enable edge/bit counter (counter clears while low)
- deser_en  out  1  enable deserializer shifting
- data_valid  out  1  one-cycle pulse: frame received without error
- stp_chk_en  out  1  enable stop checker
- strt_chk_en  out  1  enable start checker
- par_chk_en  out  1  enable parity checker

## Operation
- States: IDLE, START, DATA, PARITY, STOP, VALID. 3-bit state register; all outputs Moore, decoded combinationally from state.
- "Bit end" = `edge_cnt == 7`.
- IDLE: RX_IN == 0 → START; else stay.
- START: at bit end: strt_glitch = 1 → IDLE; else → DATA.
- DATA: at bit end with bit_cnt == 8: PAR_EN = 1 → PARITY, else → STOP. Otherwise stay.
- PARITY: at bit end: par_err = 1 → IDLE; else → STOP.
- STOP: at bit end: stp_err = 1 → IDLE; else → VALID.
- VALID: unconditional next: RX_IN == 0 → START (back-to-back frame), else IDLE.
- Output decode (1 in listed states, 0 elsewhere):
  - enable: START, DATA, PARITY, STOP
  - dat_samp_en: START, DATA, PARITY, STOP
  - strt_chk_en: START
  - deser_en: DATA
  - par_chk_en: PARITY
  - stp_chk_en: STOP
  - data_valid: VALID
- PAR_EN is sampled only at the DATA→next decision; changes elsewhere have no effect on the current frame.
- Error inputs are ignored outside their owning state and outside bit end.
- Unused state encodings → IDLE next cycle, all outputs 0.

## Timing
- RST = 1: state forced to IDLE immediately (async); all outputs 0 while reset held and until first START entry.
- Reset mid-frame aborts the frame; no data_valid.
- IDLE→START: one cycle after RX_IN falls (registered); enable asserts that cycle.
- Every transition takes effect on the rising edge on which its condition is true; outputs follow in the same cycle (no extra latency).
- data_valid: exactly one CLK cycle, the cycle after STOP bit end with stp_err = 0.
- Error exit (glitch/parity/stop): state is IDLE on next cycle; enable drops, clearing the counters.
- Simultaneous bit end with bit_cnt ≠ 8 in DATA: stay in DATA.

## Test plan
- Reset: assert RST = 1 asynchronously mid-cycle → all outputs 0 immediately; state IDLE after release.
- No-parity frame: RX_IN = 0, then edge_cnt = 7 at bit_cnt 0, 8, 9 with all errors 0 → states START, DATA, STOP, VALID; strt_chk_en/deser_en/stp_chk_en in turn; data_valid = 1 for one cycle; then IDLE with RX_IN = 1.
- Parity frame: PAR_EN = 1, par_err = 0 → DATA→PARITY at bit_cnt 8 / edge_cnt 7; par_chk_en = 1; then STOP, VALID, data_valid pulse.
- Start glitch: strt_glitch = 1 at edge_cnt 7 in START → IDLE next cycle; enable = 0; no deser_en, no data_valid.
- Parity/stop error: par_err = 1 in PARITY or stp_err = 1 in STOP at edge_cnt 7 → IDLE; data_valid stays 0.
- Back-to-back: RX_IN = 0 during VALID → START next cycle (no IDLE cycle); second frame completes with its own data_valid pulse.
